// File: rtl/gcd_unit_if.sv
// gcd_unit_if: request/response bundle for the gcd_unit engine.
//   start, a, b                  : request side, driven by the master
//   busy, done                   : engine status, driven by the slave
//   result, steps, zero_err      : response held by the slave until the next accepted request
// The master modport is for whoever issues requests.
// The slave modport is for the engine itself.
interface gcd_unit_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              start;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic [STEP_W-1:0] steps;
    logic              zero_err;

    modport master (
        output start, a, b,
        input  busy, done, result, steps, zero_err
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, steps, zero_err
    );
endinterface

// File: rtl/gcd_unit.sv
// gcd_unit: Euclid GCD engine with an integrated restoring divider.
// Each remainder X mod Y takes WIDTH clocks, producing one quotient bit per clock.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : gcd_unit_if slave, which carries the following signals
//            - start/a/b in
//            - busy/done/result/steps/zero_err out
// Latency from the accepting edge t0 is t0+2+k*(WIDTH+1), where k is the number of division steps.
module gcd_unit #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    gcd_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DIV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              zero_q, zero_d;

    // One restoring-division step.
    // The shifted remainder can be one bit wider than Y, so the compare is done at WIDTH+1 bits.
    // The difference is known to be below Y, so the low WIDTH bits of the subtraction are exact.
    logic [WIDTH:0]    div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem;

    assign div_shift = {rem_q, dvd_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, y_q});
    assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - y_q) : div_shift[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            steps_q  <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        steps_d  = steps_q;
        zero_d   = zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.a;
                    y_d     = bus.b;
                    steps_d = '0;
                    zero_d  = (bus.a == '0) && (bus.b == '0);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (y_q == '0) begin
                    result_d = x_q;
                    state_d  = S_DONE;
                end else begin
                    rem_d   = '0;
                    dvd_d   = x_q;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = div_rem;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    x_d = y_q;
                    y_d = div_rem;
                    // The step counter saturates rather than wrapping.
                    if (steps_q != '1) begin
                        steps_d = steps_q + STEP_W'(1);
                    end
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.steps    = steps_q;
    assign bus.zero_err = zero_q;
endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: scoreboard bench for gcd_unit.
// It drives an 8-bit instance and a 16-bit instance, the latter with a saturating 3-bit step counter.
// The stimulus tasks push hand-computed expected responses into a queue.
// Per-instance monitors pop an entry on every done pulse.
// Each monitor compares result, steps and zero_err against the entry, and also the latency from the accepting edge.
module tb_gcd_unit;
    localparam int P = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #(P/2) clk = ~clk;

    gcd_unit_if #(.WIDTH(8),  .STEP_W(4)) bus8  ();
    gcd_unit_if #(.WIDTH(16), .STEP_W(3)) bus16 ();

    gcd_unit #(.WIDTH(8), .STEP_W(4)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    gcd_unit #(.WIDTH(16), .STEP_W(3)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    typedef struct {
        int  res;
        int  steps;
        int  zero;
        int  lat;
        time t0;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // 8-bit monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                checkOutput("w8 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("w8 result",   32'(bus8.result),   32'(e.res));
                checkOutput("w8 steps",    32'(bus8.steps),    32'(e.steps));
                checkOutput("w8 zero_err", 32'(bus8.zero_err), 32'(e.zero));
                checkOutput("w8 busy in done", 32'(bus8.busy), 32'd0);
                checkOutput("w8 latency",  32'(($time - e.t0 - P/2) / P), 32'(e.lat));
            end
        end
    end

    // 16-bit monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus16.done === 1'b1) begin
            if (q16.size() == 0) begin
                checkOutput("w16 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                checkOutput("w16 result",   32'(bus16.result),   32'(e.res));
                checkOutput("w16 steps",    32'(bus16.steps),    32'(e.steps));
                checkOutput("w16 zero_err", 32'(bus16.zero_err), 32'(e.zero));
                checkOutput("w16 latency",  32'(($time - e.t0 - P/2) / P), 32'(e.lat));
            end
        end
    end

    // Issue one request to the 8-bit instance and wait, with a bound, for its done.
    // The repulse argument re-requests 100/75 while the engine is busy; that request must be ignored.
    // The doneStart argument raises start during the DONE cycle; that request must also be ignored.
    task automatic applyStimulus(
        input int a,         input int b,
        input int expRes,    input int expSteps,
        input int expZero,   input int k,
        input bit repulse,   input bit doneStart
    );
        exp_t e;
        int   lat;
        bit   seen;
        lat  = 2 + k * 9;
        seen = 1'b0;
        @(negedge clk);
        bus8.a     = 8'(a);
        bus8.b     = 8'(b);
        bus8.start = 1'b1;
        @(posedge clk);
        e.res   = expRes;
        e.steps = expSteps;
        e.zero  = expZero;
        e.lat   = lat;
        e.t0    = $time;
        q8.push_back(e);
        #1;
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        for (int m = 0; m <= lat + 20; m++) begin
            @(negedge clk);
            if (m == 0) checkOutput("w8 busy after accept", 32'(bus8.busy), 32'd1);
            if (m == lat - 1) checkOutput("w8 busy before done", 32'(bus8.busy), 32'd1);
            if (repulse) begin
                if (m == 3) begin
                    bus8.start = 1'b1;
                    bus8.a     = 8'd100;
                    bus8.b     = 8'd75;
                end else if (m == 4) begin
                    bus8.start = 1'b0;
                end
            end
            if (bus8.done === 1'b1) begin
                seen = 1'b1;
                if (doneStart) begin
                    bus8.start = 1'b1;
                    bus8.a     = 8'd1;
                    bus8.b     = 8'd1;
                end
                break;
            end
        end
        if (!seen) checkOutput("w8 done timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit seen16;
        bus8.start  = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        bus16.start = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;

        $display("[TB] reset phase");
        repeat (3) @(negedge clk);
        checkOutput("rst busy",     32'(bus8.busy),     32'd0);
        checkOutput("rst done",     32'(bus8.done),     32'd0);
        checkOutput("rst result",   32'(bus8.result),   32'd0);
        checkOutput("rst steps",    32'(bus8.steps),    32'd0);
        checkOutput("rst zero_err", 32'(bus8.zero_err), 32'd0);
        checkOutput("rst w16 busy", 32'(bus16.busy),    32'd0);
        reset = 1'b1;

        $display("[TB] directed vectors, width 8");
        applyStimulus(48,  18,  6,   3, 0, 3, 1'b1, 1'b1);
        applyStimulus(100, 75,  25,  2, 0, 2, 1'b0, 1'b0);
        applyStimulus(18,  48,  6,   4, 0, 4, 1'b0, 1'b0);
        applyStimulus(255, 255, 255, 1, 0, 1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hold result", 32'(bus8.result), 32'd255);
        checkOutput("hold steps",  32'(bus8.steps),  32'd1);
        checkOutput("hold done",   32'(bus8.done),   32'd0);
        applyStimulus(0,   0,   0,   0, 1, 0, 1'b0, 1'b0);
        applyStimulus(37,  0,   37,  0, 0, 0, 1'b0, 1'b0);
        applyStimulus(0,   37,  37,  1, 0, 1, 1'b0, 1'b0);

        $display("[TB] reset during division");
        @(negedge clk);
        bus8.a     = 8'd48;
        bus8.b     = 8'd18;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("pre-reset busy", 32'(bus8.busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid-reset busy",     32'(bus8.busy),     32'd0);
        checkOutput("mid-reset done",     32'(bus8.done),     32'd0);
        checkOutput("mid-reset result",   32'(bus8.result),   32'd0);
        checkOutput("mid-reset steps",    32'(bus8.steps),    32'd0);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        applyStimulus(18,  48,  6,   4, 0, 4, 1'b0, 1'b0);

        $display("[TB] fibonacci pair, width 16");
        @(negedge clk);
        bus16.a     = 16'd46368;
        bus16.b     = 16'd28657;
        bus16.start = 1'b1;
        @(posedge clk);
        q16.push_back('{res: 1, steps: 7, zero: 0, lat: 2 + 22 * 17, t0: $time});
        #1;
        bus16.start = 1'b0;
        seen16 = 1'b0;
        for (int m = 0; m <= 420; m++) begin
            @(negedge clk);
            if (bus16.done === 1'b1) begin
                seen16 = 1'b1;
                break;
            end
        end
        if (!seen16) checkOutput("w16 done timeout", 32'd0, 32'd1);

        repeat (3) @(negedge clk);
        checkOutput("w8 queue drained",  32'(q8.size()),  32'd0);
        checkOutput("w16 queue drained", 32'(q16.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gcd_unit.md
Name: gcd_unit

Overview:
Parametrised GCD engine: control FSM plus datapath computing gcd(a,b) by Euclid's algorithm. Each remainder is computed by an internal restoring divider, one quotient bit per clock. Handshake is start/busy/done; the iteration count and a zero-operand flag are reported alongside the result. Sits behind the same start-driven control style as the existing GCD controller and replaces the external divider/complete loop with an integrated one.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
STEP_W, 4, width of the steps counter (saturating)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
start  input  1  request; accepted only in IDLE
a  input  WIDTH  operand A, sampled on the accepting edge only
b  input  WIDTH  operand B, sampled on the accepting edge only
busy  output  1  high in every state except IDLE and DONE
done  output  1  one-cycle pulse, high while in DONE
result  output  WIDTH  gcd, valid from done onward, held until next accept
steps  output  STEP_W  number of division steps performed, held with result
zero_err  output  1  high with result when a==0 and b==0, held with result

Behaviour:
- One clock domain; reset synchronous, active-low. On reset: state=IDLE, busy=0, done=0, result=0, steps=0, zero_err=0, internal X/Y/remainder/counters=0.
- Reset asserted mid-operation: next edge forces IDLE and clears all outputs; the partial result is discarded and no done is issued.
- States: IDLE, LOAD, CHECK, DIV, DONE.
- IDLE: when start=1 -> LOAD, capture X<=a, Y<=b, steps<=0, zero_err<=(a==0 && b==0).
- LOAD: one cycle -> CHECK.
- CHECK: Y==0 -> DONE, result<=X. Otherwise -> DIV, initialise divider with remainder=0, dividend=X, bit counter=WIDTH.
- DIV: exactly WIDTH cycles. Each cycle: shift the dividend MSB into the remainder; subtract Y if remainder>=Y. Use a WIDTH+1-bit compare/subtract so there is no overflow at WIDTH-bit maxima. After the last bit: X<=Y, Y<=final remainder, steps<=steps+1 (saturates at 2^STEP_W-1), -> CHECK.
- DONE: done=1 for exactly one cycle -> IDLE. result, steps and zero_err hold until the next accepting edge.
- start while busy, or in DONE: ignored, no queuing. start in IDLE on the cycle after DONE: accepted normally.
- Operand cases: a<b needs no special path; the first step yields X=b, Y=a. b==0 gives result=a with steps=0. a==0, b!=0 gives one step with result=b. a==b==0 gives result=0, zero_err=1, steps=0.
- Latency: with accepting edge t0 and k division steps, done is high in the cycle after edge t0+2+k*(WIDTH+1).
- a and b are don't-care outside the accepting edge.

Test Plan:
- WIDTH=8, a=48, b=18, start pulse -> steps 48/18, 18/12, 12/6 (k=3); done high after edge t0+29; result=6, steps=3, zero_err=0; busy high t0+1..t0+28.
- a=18, b=48 -> result=6, steps=4 (first step swaps); a=255, b=255 -> result=255, steps=1; a=0, b=0 -> done after t0+2, result=0, zero_err=1, steps=0.
- a=37, b=0 -> done after t0+2, result=37, steps=0. a=0, b=37 -> result=37, steps=1.
- Re-pulse start with a=100, b=75 during busy of the 48/18 run -> ignored; result=6. Then start in the cycle after done with a=100, b=75 -> result=25, steps=2.
- Assert reset=0 for one cycle midway through DIV -> IDLE, busy=0, result=0, no done pulse; a new start afterwards completes correctly.
- WIDTH=16, STEP_W=3, Fibonacci pair a=46368, b=28657 -> result=1, steps saturates at 7, latency consistent with the actual k=22.
